instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: ADDR_W, default 5, program-memory address width (depth 2**ADDR_W words of 9 bits).
REQ-002 Parameter: TIMEOUT, default 15, max cycles waited per Done phase before error (used only with FETCH_TIMEOUT_EN).
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Resetn  input  1  reset, synchronous, active-low.
REQ-005 Start  input  1  begin program execution from address 0 (sampled in IDLE/HALT/ERROR only).
REQ-006 LoadEn  input  1  write LoadData to program memory at LoadAddr (honoured in IDLE/HALT/ERROR only).
REQ-007 LoadAddr  input  ADDR_W  program-memory write address.
REQ-008 LoadData  input  9  program word (iiixxxyyy or immediate).
REQ-009 Done  input  1  completion flag from the downstream processor.
REQ-010 DIN  output  9  instruction/immediate word to processor DIN.
REQ-011 Run  output  1  execute strobe to processor Run.
REQ-012 PC  output  ADDR_W  address of word currently driven on DIN.
REQ-013 Busy  output  1  high in any state other than IDLE, HALT, ERROR.
REQ-014 Halted  output  1  high in HALT.
REQ-015 Error  output  1  high in ERROR.

Function
REQ-016 States: IDLE, SETUP, ISSUE, IMM, WAIT_LO, WAIT_HI, HALT, ERROR; all outputs registered.
REQ-017 IDLE/HALT/ERROR + Start=1 -> SETUP, PC=0; Start ignored in other states; LoadEn and Start in same cycle: write occurs, then SETUP.
REQ-018 SETUP (1 cycle): DIN=mem[PC], Run=0; if DIN[8:6]=3'b111 (HALT word) -> HALT, else -> ISSUE.
REQ-019 ISSUE (1 cycle): DIN held, Run=1; opcode 3'b001 (MVI) -> IMM with PC=PC+1, else -> WAIT_LO.
REQ-020 IMM (1 cycle): DIN=mem[PC] (immediate), Run=0 -> WAIT_LO.
REQ-021 Opcodes 3'b100..3'b110 are issued as normal one-word instructions.
REQ-022 WAIT_LO: Run=0, DIN held; Done=0 -> WAIT_HI.
REQ-023 WAIT_HI: Done=1 -> PC=PC+1, SETUP.
REQ-024 PC increment at last address (2**ADDR_W-1) -> HALT instead of wrapping; PC holds last address.
REQ-025 MVI opcode at last address -> ERROR (no immediate available).
REQ-026 Run is high exactly one cycle per instruction; never high outside ISSUE.
REQ-027 Program memory: 2**ADDR_W x 9, synchronous write, combinational read; contents unaffected by reset.

Reset
REQ-028 Resetn=0 at a rising edge -> IDLE, DIN=0, Run=0, PC=0, Busy=0, Halted=0, Error=0, timeout counter=0.
REQ-029 Reset mid-instruction aborts immediately; no further Run pulse until a new Start.
REQ-030 Resetn=0 overrides Start and LoadEn in the same cycle (no memory write).

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN defined: counter cleared on entering WAIT_LO/WAIT_HI, increments each cycle there; reaching TIMEOUT without required Done level -> ERROR.
REQ-032 FETCH_TIMEOUT_EN undefined: no counter; WAIT_LO/WAIT_HI wait indefinitely; ERROR reachable only via REQ-025.

Verification
REQ-033 Load mem[0]=9'o100 (MVI R0), mem[1]=9'd5, mem[2]=9'o700 (HALT); Start -> SETUP DIN=9'o100 Run=0, ISSUE Run=1, IMM DIN=5 PC=1, then after Done 1->0->1, SETUP at PC=2, HALT, Halted=1.
REQ-034 mem[0]=9'o201 (ADD R0,R1), mem[1]=9'o700; Done held low 3 cycles then high -> exactly one Run pulse, PC=1 only after Done high, then HALT.
REQ-035 All 32 words 9'o010 (MV R1,R0), Done toggled per instruction -> 32 Run pulses, HALT with PC=31, no wrap to 0.
REQ-036 mem[31]=9'o100 reached -> ERROR, Error=1, Run=0; Start then restarts at PC=0.
REQ-037 Resetn=0 during WAIT_HI at PC=3 -> next cycle IDLE, all outputs 0, memory contents intact (readback by rerun).
REQ-038 With FETCH_TIMEOUT_EN, TIMEOUT=15, Done stuck 1 after ISSUE -> ERROR after 15 cycles in WAIT_LO; without macro, stays in WAIT_LO.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: sequences a 9-bit program memory into a downstream processor.
// Each instruction is presented on DIN with a one-cycle Run strobe; MVI words
// are followed by their immediate word, and the fetcher then waits for the
// processor's Done flag to go low and then high before moving on.
// Optional feature: define FETCH_TIMEOUT_EN to add a per-phase Done watchdog
// that sends the fetcher to ERROR after TIMEOUT cycles without progress.
module instr_fetch #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [8:0]        LoadData,
  input  logic              Done,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ISSUE, IMM, WAIT_LO, WAIT_HI, HALT, ERROR
  } state_t;

  localparam logic [2:0]        OP_MVI    = 3'b001;
  localparam logic [2:0]        OP_HALT   = 3'b111;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [8:0]        mem [0:(1<<ADDR_W)-1];
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc;
  logic [8:0]        din, din_n;
  logic [8:0]        first_word;
  logic              stopped;
  logic              expired;

  // Memory may only be rewritten while no program is running.
  assign stopped = (state == IDLE) || (state == HALT) || (state == ERROR);
  assign pc_inc  = pc + 1'b1;

  // A load to address 0 in the same cycle as Start must be seen by SETUP.
  assign first_word = (LoadEn && (LoadAddr == ZERO_ADDR)) ? LoadData : mem[ZERO_ADDR];

  assign DIN = din;
  assign PC  = pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tcount, tcount_n;

  assign expired = (tcount == CNT_LAST);

  // Watchdog count restarts on each entry to a Done phase and runs while waiting.
  always_comb begin
    tcount_n = tcount;
    if ((state_n != state) && ((state_n == WAIT_LO) || (state_n == WAIT_HI))) begin
      tcount_n = '0;
    end else if ((state == WAIT_LO) || (state == WAIT_HI)) begin
      tcount_n = tcount + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      tcount <= '0;
    end else begin
      tcount <= tcount_n;
    end
  end
`else
  assign expired = 1'b0;

  // TIMEOUT has no effect in this build; the Done phases wait indefinitely.
  if (TIMEOUT < 1) begin : g_timeout_ignored
  end
`endif

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge Clock) begin
    if (Resetn && LoadEn && stopped) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  // Next-state, next-PC and next-DIN selection for the fetch sequence.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    din_n   = din;
    case (state)
      IDLE, HALT, ERROR: begin
        if (Start) begin
          state_n = SETUP;
          pc_n    = ZERO_ADDR;
          din_n   = first_word;
        end
      end
      SETUP: begin
        // An MVI in the last word has no immediate, so it is refused before Run.
        if (din[8:6] == OP_HALT) begin
          state_n = HALT;
        end else if ((din[8:6] == OP_MVI) && (pc == LAST_ADDR)) begin
          state_n = ERROR;
        end else begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (din[8:6] == OP_MVI) begin
          state_n = IMM;
          pc_n    = pc_inc;
          din_n   = mem[pc_inc];
        end else begin
          state_n = WAIT_LO;
        end
      end
      IMM: begin
        state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!Done) begin
          state_n = WAIT_HI;
        end else if (expired) begin
          state_n = ERROR;
        end
      end
      WAIT_HI: begin
        if (Done) begin
          if (pc == LAST_ADDR) begin
            state_n = HALT;
          end else begin
            state_n = SETUP;
            pc_n    = pc_inc;
            din_n   = mem[pc_inc];
          end
        end else if (expired) begin
          state_n = ERROR;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and decoded status flags are all registered together.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state  <= IDLE;
      pc     <= '0;
      din    <= '0;
      Run    <= 1'b0;
      Busy   <= 1'b0;
      Halted <= 1'b0;
      Error  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      din    <= din_n;
      Run    <= (state_n == ISSUE);
      Busy   <= !((state_n == IDLE) || (state_n == HALT) || (state_n == ERROR));
      Halted <= (state_n == HALT);
      Error  <= (state_n == ERROR);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch. A program-level model
// predicts the sequence of issued instructions; a monitor checks every Run
// pulse (and the immediate that follows an MVI) against that prediction.
module tb_instr_fetch;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int LAST    = DEPTH - 1;
  localparam int TIMEOUT = 15;

  logic              Clock;
  logic              Resetn;
  logic              Start;
  logic              LoadEn;
  logic [ADDR_W-1:0] LoadAddr;
  logic [8:0]        LoadData;
  logic              Done;
  logic [8:0]        DIN;
  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
  logic              Error;

  typedef struct {
    int         pc;
    logic [8:0] word;
    bit         mvi;
    int         imm_pc;
    logic [8:0] imm;
  } issue_t;

  issue_t     expq[$];
  logic [8:0] model_mem [DEPTH];
  int         checks = 0;
  int         errors = 0;
  int         done_mode = 0;
  bit         done_force = 1'b1;

  instr_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .LoadEn(LoadEn),
    .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done),
    .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted), .Error(Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One cycle of control inputs; the model memory follows any honoured load.
  task automatic applyStimulus(input bit start, input bit load_en, input int addr, input logic [8:0] data);
    Start    = start;
    LoadEn   = load_en;
    LoadAddr = addr[ADDR_W-1:0];
    LoadData = data;
    if (load_en && Resetn) model_mem[addr] = data;
    tick();
    Start  = 1'b0;
    LoadEn = 1'b0;
  endtask

  // Walk the program as the processor sees it and queue every issued instruction.
  task automatic predict(output bit exp_halt, output bit exp_err, output int exp_pc);
    int         pc;
    logic [8:0] w;
    issue_t     e;
    pc = 0;
    exp_halt = 1'b0;
    exp_err  = 1'b0;
    while (1) begin
      w = model_mem[pc];
      if (w[8:6] == 3'b111) begin exp_halt = 1'b1; break; end
      if (w[8:6] == 3'b001 && pc == LAST) begin exp_err = 1'b1; break; end
      e.pc = pc; e.word = w; e.mvi = (w[8:6] == 3'b001); e.imm_pc = 0; e.imm = 9'd0;
      if (e.mvi) begin
        pc++;
        e.imm_pc = pc;
        e.imm    = model_mem[pc];
      end
      expq.push_back(e);
      if (pc == LAST) begin exp_halt = 1'b1; break; end
      pc++;
    end
    exp_pc = pc;
  endtask

  task automatic runProgram(input bit with_load, input int laddr, input logic [8:0] ldata, input string tag);
    bit eh, ee;
    int epc, n;
    applyStimulus(1'b1, with_load, laddr, ldata);
    checkOutput({tag, "_setup_busy"}, Busy, 1);
    checkOutput({tag, "_setup_pc"}, PC, 0);
    checkOutput({tag, "_setup_run"}, Run, 0);
    checkOutput({tag, "_setup_din"}, DIN, model_mem[0]);
    predict(eh, ee, epc);
    n = 0;
    while (!(Halted || Error) && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("[TB] FAIL %s_end_timeout actual=no end after %0d cycles expected=HALT or ERROR", tag, n);
    end
    checkOutput({tag, "_halted"}, Halted, eh);
    checkOutput({tag, "_error"}, Error, ee);
    checkOutput({tag, "_end_pc"}, PC, epc);
    checkOutput({tag, "_end_run"}, Run, 0);
    @(negedge Clock);
    checkOutput({tag, "_issues_left"}, expq.size(), 0);
    expq.delete();
    tick();
  endtask

  task automatic waitRun(input string tag);
    int n;
    n = 0;
    while (Run !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL %s_run_timeout actual=no Run expected=Run pulse", tag);
    end
  endtask

  // Monitor: every Run pulse must match the next predicted instruction.
  initial begin
    issue_t cur;
    bit     imm_pending;
    imm_pending = 1'b0;
    forever begin
      @(negedge Clock);
      if (imm_pending) begin
        checkOutput("imm_din", DIN, cur.imm);
        checkOutput("imm_pc", PC, cur.imm_pc);
        checkOutput("imm_run", Run, 0);
        imm_pending = 1'b0;
      end
      if (Run === 1'b1) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_run actual=PC %0d DIN %0o expected=no Run", PC, DIN);
        end else begin
          cur = expq.pop_front();
          checkOutput("issue_pc", PC, cur.pc);
          checkOutput("issue_din", DIN, cur.word);
          imm_pending = cur.mvi;
        end
      end
    end
  end

  // Processor stand-in: after each Run, Done stays high a little, drops, then rises.
  initial begin
    int hold, low;
    bit active;
    Done = 1'b1; active = 1'b0; hold = 0; low = 0;
    forever begin
      @(posedge Clock);
      #2;
      if (done_mode == 1) begin
        Done = done_force; active = 1'b0;
      end else if (Run === 1'b1) begin
        active = 1'b1; hold = $urandom_range(3, 1); low = $urandom_range(3, 1); Done = 1'b1;
      end else if (active) begin
        if (hold > 0) begin hold--; Done = 1'b1; end
        else if (low > 0) begin low--; Done = 1'b0; end
        else begin Done = 1'b1; active = 1'b0; end
      end else begin
        Done = 1'b1;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int         n;
    int         op;
    logic [8:0] w;
    Resetn = 1'b0; Start = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 9'o000;
    tick(); tick();
    checkOutput("reset_din", DIN, 0);
    checkOutput("reset_run", Run, 0);
    checkOutput("reset_pc", PC, 0);
    checkOutput("reset_busy", Busy, 0);
    checkOutput("reset_halted", Halted, 0);
    checkOutput("reset_error", Error, 0);
    Resetn = 1'b1;
    tick();

    // MVI R0,#5 then HALT
    applyStimulus(1'b0, 1'b1, 0, 9'o100);
    applyStimulus(1'b0, 1'b1, 1, 9'd5);
    applyStimulus(1'b0, 1'b1, 2, 9'o700);
    runProgram(1'b0, 0, 9'd0, "mvi");

    // ADD then HALT
    applyStimulus(1'b0, 1'b1, 0, 9'o201);
    applyStimulus(1'b0, 1'b1, 1, 9'o700);
    runProgram(1'b0, 0, 9'd0, "add");

    // Full memory of MV: runs off the end into HALT at the last address
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, i, 9'o010);
    runProgram(1'b0, 0, 9'd0, "mv_all");

    // MVI in the last word goes to ERROR; Start restarts from 0
    applyStimulus(1'b0, 1'b1, LAST, 9'o100);
    runProgram(1'b0, 0, 9'd0, "mvi_last");
    runProgram(1'b0, 0, 9'd0, "restart");

    // Reset while waiting for Done high at PC 3; load and Start under reset are ignored
    applyStimulus(1'b0, 1'b1, LAST, 9'o010);
    done_mode = 1; done_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_t e;
      e.pc = i; e.word = model_mem[i]; e.mvi = 1'b0; e.imm_pc = 0; e.imm = 9'd0;
      expq.push_back(e);
    end
    applyStimulus(1'b1, 1'b0, 0, 9'd0);
    for (int i = 0; i < 4; i++) begin
      waitRun("reset_mid");
      done_force = 1'b0;
      tick(); tick();
      if (i < 3) begin done_force = 1'b1; tick(); end
    end
    checkOutput("reset_mid_pc_before", PC, 3);
    checkOutput("reset_mid_busy_before", Busy, 1);
    Resetn = 1'b0;
    applyStimulus(1'b1, 1'b1, 0, 9'o700);
    Resetn = 1'b1;
    checkOutput("reset_mid_outputs", {23'd0, DIN, Run, PC, Busy, Halted, Error}, 0);
    done_mode = 0;
    repeat (10) tick();
    checkOutput("reset_mid_busy_after", Busy, 0);
    checkOutput("reset_mid_issues_left", expq.size(), 0);
    runProgram(1'b0, 0, 9'd0, "rerun");

    // Done stuck high after an ADD
    applyStimulus(1'b0, 1'b1, 0, 9'o201);
    applyStimulus(1'b0, 1'b1, 1, 9'o700);
    begin
      issue_t e;
      e.pc = 0; e.word = 9'o201; e.mvi = 1'b0; e.imm_pc = 0; e.imm = 9'd0;
      expq.push_back(e);
    end
    done_mode = 1; done_force = 1'b1;
    applyStimulus(1'b1, 1'b0, 0, 9'd0);
    waitRun("stuck");
    n = 0;
`ifdef FETCH_TIMEOUT_EN
    while (!Error && n < 60) begin tick(); n++; end
    checkOutput("stuck_cycles_to_error", n, TIMEOUT + 1);
    checkOutput("stuck_error", Error, 1);
    checkOutput("stuck_busy", Busy, 0);
`else
    repeat (40) begin tick(); n++; end
    checkOutput("stuck_busy", Busy, 1);
    checkOutput("stuck_error", Error, 0);
    checkOutput("stuck_run", Run, 0);
`endif
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    done_mode = 0;
    tick();
    checkOutput("stuck_issues_left", expq.size(), 0);

    // Random programs, some with a load coinciding with Start
    for (int iter = 0; iter < 8; iter++) begin
      for (int i = 0; i < DEPTH; i++) begin
        op = $urandom_range(6, 0);
        if ($urandom_range(19, 0) == 0) op = 7;
        w = {3'(op), 6'($urandom)};
        applyStimulus(1'b0, 1'b1, i, w);
      end
      op = $urandom_range(6, 0);
      w = {3'(op), 6'($urandom)};
      runProgram(1'($urandom_range(1, 0)), $urandom_range(LAST, 0), w, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
